// File: rtl/nes_dma_pkg.sv
// Shared types and constants for the sprite OAM DMA engine.
package nes_dma_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    GET,
    PUT
  } dma_state_e;

  localparam logic [15:0] DMA_REG_ADDR  = 16'h4014;
  localparam logic [15:0] OAM_DATA_ADDR = 16'h2004;
  localparam int          OAM_LEN       = 256;
  localparam logic [7:0]  LAST_IDX      = 8'(OAM_LEN - 1);

endpackage

// File: rtl/oam_dma_ctrl.sv
// OAM DMA: halts the CPU on a $4014 write, then copies page $XX00-$XXFF to $2004.
// 513/514 cycles (+1 per CPU write seen while halting); the CPU is stalled via registered CPU_RDY.
module oam_dma_ctrl
  import nes_dma_pkg::*;
(
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [15:0] CPU_ADDR,
  input  logic        CPU_R_WN,
  input  logic [7:0]  CPU_ODATA,
  output logic        CPU_RDY,
  output logic        BUS_SEL,
  output logic [15:0] BUS_ADDR,
  output logic        BUS_R_WN,
  output logic [7:0]  BUS_ODATA,
  input  logic [7:0]  BUS_IDATA,
  output logic        DMA_BUSY
);

  dma_state_e state;
  dma_state_e state_nxt;
  logic [7:0] page;
  logic [7:0] idx;
  logic [7:0] data_buf;
  logic       par;
  logic       rdy;
  logic       busy;
  logic       trigger;
  logic       last_put;

  assign trigger  = (state == IDLE) && !CPU_R_WN && (CPU_ADDR == DMA_REG_ADDR) && rdy;
  assign last_put = (state == PUT) && (idx == LAST_IDX);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Parity runs freely; GET is always placed on a par==0 cycle.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      par      <= 1'b0;
      page     <= 8'h00;
      idx      <= 8'h00;
      data_buf <= 8'h00;
      rdy      <= 1'b1;
      busy     <= 1'b0;
    end else begin
      par <= ~par;
      if (trigger) begin
        page <= CPU_ODATA;
        idx  <= 8'h00;
        rdy  <= 1'b0;
        busy <= 1'b1;
      end
      if (state == GET) begin
        data_buf <= BUS_IDATA;
      end
      if (state == PUT) begin
        idx <= idx + 8'h01;
      end
      if (last_put) begin
        rdy  <= 1'b1;
        busy <= 1'b0;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    BUS_SEL   = 1'b0;
    BUS_ADDR  = 16'h0000;
    BUS_R_WN  = 1'b1;
    BUS_ODATA = 8'h00;
    case (state)
      IDLE: begin
        if (trigger) state_nxt = HALT;
      end
      HALT: begin
        // A CPU write cycle cannot be stalled, so wait for its first read.
        if (CPU_R_WN) state_nxt = par ? GET : ALIGN;
      end
      ALIGN: begin
        state_nxt = GET;
      end
      GET: begin
        state_nxt = PUT;
        BUS_SEL   = 1'b1;
        BUS_ADDR  = {page, idx};
      end
      PUT: begin
        state_nxt = (idx == LAST_IDX) ? IDLE : GET;
        BUS_SEL   = 1'b1;
        BUS_ADDR  = OAM_DATA_ADDR;
        BUS_R_WN  = 1'b0;
        BUS_ODATA = data_buf;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign CPU_RDY  = rdy;
  assign DMA_BUSY = busy;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Self-checking bench for oam_dma_ctrl against a cycle-timeline reference model.
module tb_oam_dma_ctrl;
  import nes_dma_pkg::*;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [15:0] CPU_ADDR;
  logic        CPU_R_WN;
  logic [7:0]  CPU_ODATA;
  logic        CPU_RDY;
  logic        BUS_SEL;
  logic [15:0] BUS_ADDR;
  logic        BUS_R_WN;
  logic [7:0]  BUS_ODATA;
  logic [7:0]  BUS_IDATA;
  logic        DMA_BUSY;

  logic [7:0] ram [0:65535];
  logic       par_m;
  int         n_cmp = 0;
  int         n_bad = 0;

  oam_dma_ctrl dut (
    .CLK(CLK), .RST_N(RST_N),
    .CPU_ADDR(CPU_ADDR), .CPU_R_WN(CPU_R_WN), .CPU_ODATA(CPU_ODATA),
    .CPU_RDY(CPU_RDY), .BUS_SEL(BUS_SEL), .BUS_ADDR(BUS_ADDR),
    .BUS_R_WN(BUS_R_WN), .BUS_ODATA(BUS_ODATA), .BUS_IDATA(BUS_IDATA),
    .DMA_BUSY(DMA_BUSY)
  );

  always #5 CLK = ~CLK;

  assign BUS_IDATA = ram[BUS_ADDR];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Parity model: 0 while reset is sampled, otherwise flips every cycle.
  task automatic step();
    @(posedge CLK);
    par_m = RST_N ? ~par_m : 1'b0;
    #1;
  endtask

  task automatic cpu_idle();
    CPU_R_WN  = 1'b1;
    CPU_ADDR  = 16'($urandom);
    CPU_ODATA = 8'($urandom);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_rdy"},   CPU_RDY,   1);
    chk({tag, "_sel"},   BUS_SEL,   0);
    chk({tag, "_addr"},  BUS_ADDR,  0);
    chk({tag, "_rwn"},   BUS_R_WN,  1);
    chk({tag, "_odata"}, BUS_ODATA, 0);
    chk({tag, "_busy"},  DMA_BUSY,  0);
  endtask

  // want_align: 0 or 1 forces the ALIGN outcome by idling a cycle first; any other value leaves it random.
  task automatic xfer(input logic [7:0] pg, input int extra, input int want_align, output logic [7:0] last);
    int pr, align, start, total, k, gi, pi;
    pr    = (par_m ? 0 : 1) ^ (extra & 1);
    align = (pr == 0) ? 1 : 0;
    if ((want_align == 0 || want_align == 1) && align != want_align) begin
      cpu_idle();
      step();
      pr    = (par_m ? 0 : 1) ^ (extra & 1);
      align = (pr == 0) ? 1 : 0;
    end
    chk("rdy_pre_trigger", CPU_RDY, 1);
    CPU_ADDR  = DMA_REG_ADDR;
    CPU_R_WN  = 1'b0;
    CPU_ODATA = pg;
    step();
    start = 1 + extra + align;
    total = start + 2 * OAM_LEN;
    k = 0; gi = 0; pi = 0; last = 8'h00;
    while (CPU_RDY === 1'b0 && k < 600) begin
      if (k < extra) begin
        CPU_R_WN  = 1'b0;
        CPU_ADDR  = 16'h0100 + 16'(k);
        CPU_ODATA = 8'($urandom);
      end else begin
        cpu_idle();
      end
      chk("busy_during", DMA_BUSY, 1);
      if (k < start) begin
        chk("halt_sel",  BUS_SEL,  0);
        chk("halt_addr", BUS_ADDR, 0);
        chk("halt_rwn",  BUS_R_WN, 1);
      end else if (((k - start) % 2) == 0) begin
        chk("get_sel",  BUS_SEL,  1);
        chk("get_rwn",  BUS_R_WN, 1);
        chk("get_addr", BUS_ADDR, {16'h0, pg, 8'(gi)});
        gi++;
      end else begin
        chk("put_sel",  BUS_SEL,  1);
        chk("put_rwn",  BUS_R_WN, 0);
        chk("put_addr", BUS_ADDR, OAM_DATA_ADDR);
        chk("put_data", BUS_ODATA, ram[{pg, 8'(pi)}]);
        last = BUS_ODATA;
        pi++;
      end
      step();
      k++;
    end
    chk("stall_cycles", k, total);
    chk("put_count", pi, OAM_LEN);
    chk_reset_outs("post_xfer");
    cpu_idle();
  endtask

  initial begin
    logic [7:0] last;
    logic [7:0] pg;
    int found;

    par_m = 1'b0;
    RST_N = 1'b0;
    cpu_idle();
    for (int i = 0; i < 65536; i++) ram[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) ram[16'h0200 + i] = 8'(i) ^ 8'h5A;
    for (int i = 0; i < 3; i++) step();
    chk_reset_outs("reset");
    RST_N = 1'b1;
    step();
    chk_reset_outs("idle_after_reset");

    // Non-triggering accesses.
    for (int i = 0; i < 20; i++) begin
      case (i % 3)
        0: begin CPU_R_WN = 1'b1; CPU_ADDR = 16'h4014; end
        1: begin CPU_R_WN = 1'b0; CPU_ADDR = 16'h4015; end
        default: begin CPU_R_WN = 1'b0; CPU_ADDR = 16'h2014; end
      endcase
      CPU_ODATA = 8'($urandom);
      step();
      chk("nontrig_rdy", CPU_RDY, 1);
      chk("nontrig_sel", BUS_SEL, 0);
      chk("nontrig_busy", DMA_BUSY, 0);
    end
    cpu_idle();
    step();

    // Even and odd alignment, then CPU write cycles during HALT.
    xfer(8'h02, 0, 0, last);
    chk("even_last", last, 8'hA5);
    step();
    xfer(8'h02, 0, 1, last);
    chk("odd_last", last, 8'hA5);
    step();
    xfer(8'h02, 2, 2, last);
    chk("rmw_last", last, 8'hA5);
    step();

    // Reset in the middle of a transfer, at the GET for idx $80.
    CPU_ADDR = DMA_REG_ADDR; CPU_R_WN = 1'b0; CPU_ODATA = 8'h02;
    step();
    found = 0;
    for (int k = 0; k < 600 && found == 0; k++) begin
      cpu_idle();
      if (BUS_SEL === 1'b1 && BUS_R_WN === 1'b1 && BUS_ADDR === 16'h0280) found = 1;
      else step();
    end
    chk("reach_idx80", found, 1);
    RST_N = 1'b0;
    step();
    chk_reset_outs("midreset_1");
    step();
    chk_reset_outs("midreset_2");
    RST_N = 1'b1;
    step();
    chk_reset_outs("after_midreset");
    for (int i = 0; i < 256; i++) ram[16'h0300 + i] = 8'($urandom);
    xfer(8'h03, 0, 2, last);
    step();

    // Randomized transfers: page, RAM contents, gap and HALT write cycles.
    for (int t = 0; t < 6; t++) begin
      pg = (t == 0) ? 8'h40 : 8'($urandom);
      for (int i = 0; i < 256; i++) ram[{pg, 8'(i)}] = 8'($urandom);
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
        cpu_idle();
        step();
      end
      xfer(pg, int'($urandom_range(0, 3)), 2, last);
      chk("rand_last", last, ram[{pg, 8'hFF}]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
